// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, the NOP encoding and the IF/ID
// pipeline register layout reused by the ID stage.
package mips_pkg;

    localparam int INSTR_W  = 32;
    localparam int ADDR_W   = 32;
    localparam int OPCODE_W = 6;

    // All-zero word: decodes as an R-type write to $0, i.e. a harmless bubble.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Flush beats load; with neither asserted the
// contents hold. Reset and flush both produce the bubble encoding.
module if_id_register
    import mips_pkg::*;
(
    input  logic   clock_in,
    input  logic   reset_n_in,
    input  logic   load_in,
    input  logic   flush_in,
    input  if_id_t d_in,
    output if_id_t q_out
);

    // Bubble / load / hold selection for the pipeline register.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            q_out <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else if (flush_in) begin
            q_out <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else if (load_in) begin
            q_out <= d_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, imem address and IF/ID register.
// Optional feature macro: FETCH_DELAY_SLOT_EN -- when defined, a redirect
// keeps the instruction fetched in that cycle (branch delay slot) instead of
// flushing IF/ID to a bubble. The PC takes the target either way.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock_in,
    input  logic        reset_n_in,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              ifid_load;
    logic              ifid_flush;
    if_id_t            ifid_d;
    if_id_t            ifid_q;

    // Wraps modulo 2^32 naturally.
    assign pc_plus4 = pc + 32'd4;

    // PC next state: redirect (older instruction) overrides the stall.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pc <= RESET_PC;
        end else if (redirect_in) begin
            pc <= {redirect_pc_in[31:2], 2'b00};
        end else if (!stall_in) begin
            pc <= pc_plus4;
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    // The delay-slot instruction is fetched this cycle and must execute.
    assign ifid_flush = 1'b0;
    assign ifid_load  = redirect_in | ~stall_in;
`else
    assign ifid_flush = redirect_in;
    assign ifid_load  = ~stall_in;
`endif

    assign ifid_d = '{instr: imem_data_in, pc_plus4: pc_plus4, valid: 1'b1};

    if_id_register u_if_id (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .load_in    (ifid_load),
        .flush_in   (ifid_flush),
        .d_in       (ifid_d),
        .q_out      (ifid_q)
    );

    assign imem_addr_out = pc;
    assign instr_out     = ifid_q.instr;
    assign opcode_out    = ifid_q.instr[31:26];
    assign pc_plus4_out  = ifid_q.pc_plus4;
    assign valid_out     = ifid_q.valid;

endmodule
